// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: func3 width codes, writeback select,
// bus widths and the memory-access FSM state type.
package mem_stage_pkg;

  localparam int REG_BUS_W   = 5;
  localparam int DATA_BUS_W  = 32;
  localparam int FUNC3_BUS_W = 3;

  localparam logic [FUNC3_BUS_W-1:0] OP_LB  = 3'b000;
  localparam logic [FUNC3_BUS_W-1:0] OP_LH  = 3'b001;
  localparam logic [FUNC3_BUS_W-1:0] OP_LW  = 3'b010;
  localparam logic [FUNC3_BUS_W-1:0] OP_LBU = 3'b100;
  localparam logic [FUNC3_BUS_W-1:0] OP_LHU = 3'b101;
  localparam logic [FUNC3_BUS_W-1:0] OP_SB  = 3'b000;
  localparam logic [FUNC3_BUS_W-1:0] OP_SH  = 3'b001;
  localparam logic [FUNC3_BUS_W-1:0] OP_SW  = 3'b010;

  // Writeback takes the memory path when mem2reg equals this value
  localparam logic MEM2REG = 1'b1;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RSP
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  // Access width lives in func3[1:0]; bit 2 only selects load sign handling
  function automatic mem_size_e size_of(input logic [FUNC3_BUS_W-1:0] func3);
    case (func3[1:0])
      2'b00:   size_of = SZ_BYTE;
      2'b01:   size_of = SZ_HALF;
      default: size_of = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational load/store lane alignment: misalignment detect, store shift
// with byte strobes, and right-alignment of the returned load word.
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          addr_lo,
  input  logic [2:0]          func3,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W-1:0]   load_word,
  output logic                misalign,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   load_data
);

  mem_size_e size;
  logic [4:0] lane_shift;

  assign size       = size_of(func3);
  assign lane_shift = {addr_lo, 3'b000};

  always_comb begin
    misalign = 1'b0;
    wstrb    = '0;
    case (size)
      SZ_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        wstrb    = 4'b0011 << addr_lo;
      end
      default: begin
        misalign = |addr_lo;
        wstrb    = 4'b1111;
      end
    endcase
  end

  // Load data is zero-filled at the top; sign extension happens in writeback
  assign wdata     = store_data << lane_shift;
  assign load_data = load_word >> lane_shift;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests over req/gnt/rvalid,
// stalls upstream while an access is outstanding, and registers MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_valid_i,
  input  logic [DATA_W-1:0] ex_alu_result_i,
  input  logic [DATA_W-1:0] ex_rs2_data_i,
  input  logic [2:0]        ex_func3_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic              ex_mem2reg_i,
  input  logic              ex_reg_write_i,
  input  logic [4:0]        ex_rd_i,
  output logic              stall_o,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [3:0]        dm_wstrb_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_from_reg_o,
  output logic [DATA_W-1:0] wb_from_mem_o,
  output logic [2:0]        wb_func3_o,
  output logic              wb_mem2reg_o,
  output logic              wb_reg_write_o,
  output logic [4:0]        wb_rd_o,
  output logic              misalign_o
);

  mem_state_e state, state_next;

  logic              mem_op;
  logic              misalign;
  logic              misalign_op;
  logic              aligned_op;
  logic              issue;
  logic              done;
  logic [3:0]        strb;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] load_data;

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .addr_lo   (ex_alu_result_i[1:0]),
    .func3     (ex_func3_i),
    .store_data(ex_rs2_data_i),
    .load_word (dm_rdata_i),
    .misalign  (misalign),
    .wstrb     (strb),
    .wdata     (wdata),
    .load_data (load_data)
  );

  assign mem_op      = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
  assign misalign_op = mem_op & misalign;
  assign aligned_op  = mem_op & ~misalign;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (aligned_op) begin
          stall_o    = 1'b1;
          issue      = 1'b1;
          state_next = MEM_REQ;
        end
      end
      MEM_REQ: begin
        stall_o = 1'b1;
        if (dm_gnt_i) begin
          state_next = MEM_RSP;
        end
      end
      MEM_RSP: begin
        if (dm_rvalid_i) begin
          done       = 1'b1;
          state_next = MEM_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: begin
        state_next = MEM_IDLE;
      end
    endcase
  end

  // Request fields are captured once at issue and held until the access ends
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_wstrb_o <= '0;
      dm_wdata_o <= '0;
    end else if (issue) begin
      dm_req_o   <= 1'b1;
      dm_we_o    <= ex_mem_write_i;
      dm_addr_o  <= {ex_alu_result_i[ADDR_W-1:2], 2'b00};
      dm_wstrb_o <= ex_mem_write_i ? strb : 4'b0000;
      dm_wdata_o <= ex_mem_write_i ? wdata : '0;
    end else if (state == MEM_REQ && dm_gnt_i) begin
      dm_req_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_o     <= 1'b0;
      wb_from_reg_o  <= '0;
      wb_from_mem_o  <= '0;
      wb_func3_o     <= '0;
      wb_mem2reg_o   <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_o        <= '0;
      misalign_o     <= 1'b0;
    end else if (stall_o) begin
      wb_valid_o     <= 1'b0;
      wb_from_reg_o  <= '0;
      wb_from_mem_o  <= '0;
      wb_func3_o     <= '0;
      wb_mem2reg_o   <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_o        <= '0;
      misalign_o     <= 1'b0;
    end else begin
      wb_valid_o     <= ex_valid_i;
      wb_from_reg_o  <= ex_alu_result_i;
      wb_from_mem_o  <= (done && ex_mem_read_i) ? load_data : '0;
      wb_func3_o     <= ex_func3_i;
      wb_mem2reg_o   <= ex_mem2reg_i;
      wb_reg_write_o <= ex_valid_i & ex_reg_write_i & ~misalign_op;
      wb_rd_o        <= ex_rd_i;
      misalign_o     <= misalign_op;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RV32I core; sits between EX and the writeback mux.
- Issues data-memory requests over a req/gnt/rvalid handshake and aligns store data and byte strobes.
- Right-aligns load data and registers the MEM/WB bundle consumed by writeback.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data bus width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX/MEM bundle holds a real instruction
- ex_alu_result_i  in  32  effective address, or ALU result for non-memory ops
- ex_rs2_data_i  in  32  store data
- ex_func3_i  in  3  load/store width code (`OP_LB..`OP_LHU, SB/SH/SW)
- ex_mem_read_i  in  1  load
- ex_mem_write_i  in  1  store
- ex_mem2reg_i  in  1  writeback source select (`Mem2Reg)
- ex_reg_write_i  in  1  destination write enable
- ex_rd_i  in  5  destination register
- stall_o  out  1  hold EX/MEM and all upstream stages
- dm_req_o  out  1  memory request
- dm_we_o  out  1  1 = store
- dm_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dm_wstrb_o  out  4  byte write strobes
- dm_wdata_o  out  32  lane-shifted store data
- dm_gnt_i  in  1  request accepted
- dm_rvalid_i  in  1  response/ack (loads and stores)
- dm_rdata_i  in  32  read word
- wb_valid_o, wb_from_reg_o[32], wb_from_mem_o[32], wb_func3_o[3], wb_mem2reg_o, wb_reg_write_o, wb_rd_o[5]  out  MEM/WB register
- misalign_o  out  1  one-cycle misaligned-access flag

Behaviour:
- Reset (async, rstn=0): FSM=IDLE; all wb_* outputs, misalign_o, dm_req_o, dm_we_o, dm_wstrb_o = 0; dm_addr_o and dm_wdata_o = 0.
- Mem op: ex_valid_i & (ex_mem_read_i | ex_mem_write_i). Misaligned: halfword op with addr[0]=1, or word op with addr[1:0]≠0.
- Non-memory or misaligned op: 1-cycle latency; MEM/WB register loads on the next edge; stall_o=0.
  - Misaligned: no request is issued; wb_reg_write_o=0, wb_valid_o=1, misalign_o=1 for one cycle.
- FSM IDLE→REQ: an aligned mem op in IDLE asserts stall_o combinationally; the request is latched into the dm_* registers at the edge; FSM→REQ.
- FSM REQ: dm_req_o=1, outputs held stable until dm_gnt_i; on gnt→RSP and dm_req_o drops the next cycle.
- FSM RSP: wait for dm_rvalid_i. The rvalid cycle captures the MEM/WB register (load data plus bundle) and drops stall_o; FSM→IDLE.
- stall_o = (IDLE & aligned mem op) | REQ | (RSP & !dm_rvalid_i).
- Bubbles: while stall_o=1 the MEM/WB register loads a bubble (wb_valid_o=0, wb_reg_write_o=0). Upstream holds ex_* stable while stall_o=1.
- Handshake timing: dm_rvalid_i arrives at least 1 cycle after gnt and is never in the gnt cycle. Minimum mem-op latency is 3 cycles (IDLE, REQ with gnt, RSP with rvalid). Store acks also use rvalid.
- Store alignment: off=addr[1:0]; dm_wdata_o = rs2 << (8*off).
  - dm_wstrb_o: SB = 4'b0001<<off; SH = 4'b0011<<off; SW = 4'b1111.
- Load alignment: wb_from_mem_o = dm_rdata_i >> (8*off), zero-filled at the top; sign/zero extension is done by writeback. For stores, wb_from_mem_o = 0.
- wb_from_reg_o = ex_alu_result_i; func3, mem2reg, rd and reg_write pass through unchanged.
- Reset mid-operation: FSM returns to IDLE immediately; a late dm_rvalid_i seen in IDLE is ignored.
- dm_gnt_i or dm_rvalid_i outside REQ/RSP respectively: ignored.

Decomposition:
- Shared definitions (def.v): `OP_* func3 codes, `Mem2Reg, `RegBus/`DataBus/`Func3Bus widths, and a new FSM state enum MEM_IDLE/MEM_REQ/MEM_RSP.
- Sub-module lsu_align (combinational), containing:
  - misalign detect
  - store shift and strobe generation
  - load right-shift
- mem_stage holds the FSM, request registers and MEM/WB register.

Test Plan:
- ADD result 0x1234 with rd=5 → 1 cycle later wb_from_reg_o=0x1234, wb_rd_o=5, wb_valid_o=1; stall_o never high.
- SB addr 0x102, rs2=0x000000AB; gnt after 2 cycles, rvalid 1 later → dm_addr_o=0x100, dm_wstrb_o=4'b0100, dm_wdata_o=0x00AB0000; stall_o high 4 cycles.
- LBU addr 0x203, rdata=0xCD000000 → wb_from_mem_o=0x000000CD, wb_func3_o=`OP_LBU, wb_mem2reg_o=`Mem2Reg.
- LW addr 0x302 → no dm_req_o, misalign_o=1 one cycle, wb_reg_write_o=0.
- LH addr 0x400, rstn pulsed low while in RSP → all outputs 0, FSM IDLE; a subsequent rvalid produces no wb_valid_o.
- Back-to-back SW 0x500 then LW 0x500 with gnt and rvalid immediate → second request issued the cycle after the first rvalid; load returns the stored word.
